// File: rtl/config_word_receiver.sv
// config_word_receiver: hunts for the sync word on the self-write port, then
// decodes header/data words into complete frames. Each complete frame is
// presented with its column address and a one-cycle FrameStrobe.
module config_word_receiver #(
    parameter int unsigned NUM_ROWS     = 16,
    parameter int unsigned FRAME_ADDR_W = 5,
    parameter logic [31:0] SYNC_WORD    = 32'hFAB0_FAB1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       SelfWriteStrobe,
    input  logic [31:0]                SelfWriteData,
    output logic [FRAME_ADDR_W-1:0]    FrameAddress,
    output logic [NUM_ROWS*32-1:0]     FrameData,
    output logic                       FrameStrobe,
    output logic                       ConfigActive,
    output logic                       ConfigError,
    output logic [15:0]                FrameCount
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned FRAME_W = NUM_ROWS * WORD_W;
    localparam int unsigned CNT_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned COUNT_W = 16;

    localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(NUM_ROWS - 1);
    localparam logic [3:0]         OP_WRITE   = 4'h0;
    localparam logic [3:0]         OP_DESYNC  = 4'hF;
    localparam logic [COUNT_W-1:0] COUNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_ADDR_W-1:0] addr_q, addr_d;
    logic [FRAME_W-1:0]      data_q, data_d;
    logic                    strobe_q, strobe_d;
    logic                    err_q, err_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic                    active_q;
    logic [3:0]              opcode;

    assign opcode = SelfWriteData[31:28];

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output decode; only strobed words cause changes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        err_d    = err_q;
        count_d  = count_q;

        if (SelfWriteStrobe) begin
            case (state_q)
                HUNT: begin
                    if (SelfWriteData == SYNC_WORD) begin
                        state_d = HEADER;
                    end
                end
                HEADER: begin
                    // Sync is checked before the opcode: its top nibble aliases desync
                    if (SelfWriteData == SYNC_WORD) begin
                        state_d = HEADER;
                    end else if (opcode == OP_WRITE) begin
                        addr_d  = SelfWriteData[FRAME_ADDR_W-1:0];
                        cnt_d   = '0;
                        state_d = DATA;
                    end else if (opcode == OP_DESYNC) begin
                        state_d = HUNT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
                DATA: begin
                    data_d = FRAME_W'({data_q, SelfWriteData});
                    if (cnt_q == LAST_CNT) begin
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                        state_d  = HEADER;
                        if (count_q != COUNT_MAX) begin
                            count_d = count_q + COUNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            count_q  <= count_d;
            active_q <= (state_d != HUNT);
        end
    end

    assign FrameAddress = addr_q;
    assign FrameData    = data_q;
    assign FrameStrobe  = strobe_q;
    assign ConfigActive = active_q;
    assign ConfigError  = err_q;
    assign FrameCount   = count_q;

endmodule
